// File: rtl/tlb_maint_unit_if.sv
// Shared types for the TLB maintenance unit, and the commit/CSR/mmu-facing
// interface that carries its request, result and write-request signals.
package tlb_maint_pkg;
  localparam int TLB_ENTRY_NUM = 64;
  localparam int IDX_W         = $clog2(TLB_ENTRY_NUM);
  localparam logic [5:0] ECODE_TLBR = 6'h3f;
  localparam logic [5:0] PS_HUGE    = 6'd21;
  localparam logic [2:0] OP_SRCH = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2, OP_FILL = 3'd3, OP_INV = 3'd4;

  typedef struct packed { logic [18:0] vppn; logic [5:0] ps; logic g; logic [9:0] asid; logic e; } tlb_key_t;
  typedef struct packed { logic [19:0] ppn; logic [1:0] plv; logic [1:0] mat; logic d; logic v; } tlb_page_t;
  typedef struct packed { tlb_key_t key; tlb_page_t p0; tlb_page_t p1; } tlb_entry_t;

  typedef struct packed { logic ne; logic [5:0] ps; logic [15:0] index; } tlbidx_t;
  typedef struct packed { logic [18:0] vppn; } tlbehi_t;
  typedef struct packed { logic [9:0] asid; } asid_t;
  typedef struct packed { logic [5:0] ecode; } estat_t;
  typedef struct packed {
    tlbidx_t     tlbidx;
    tlbehi_t     tlbehi;
    logic [31:0] tlbelo0;
    logic [31:0] tlbelo1;
    asid_t       asid;
    estat_t      estat;
  } csr_t;

  typedef struct packed { logic [TLB_ENTRY_NUM-1:0] we; tlb_entry_t entry; } tlb_write_req_t;
endpackage

interface tlb_maint_if;
  import tlb_maint_pkg::*;
  logic           req_valid;
  logic           req_ready;
  logic [2:0]     req_op;
  logic [4:0]     inv_op;
  logic [9:0]     inv_asid;
  logic [31:0]    inv_va;
  csr_t           csr;
  tlb_entry_t     wr_entry;
  tlb_write_req_t tlb_write_req_o;
  logic           done_o;
  logic           srch_hit_o;
  logic [IDX_W-1:0] srch_idx_o;
  tlb_entry_t     rd_entry_o;
  logic           inv_err_o;

  modport master (output req_valid, req_op, inv_op, inv_asid, inv_va, csr, wr_entry,
                  input  req_ready, tlb_write_req_o, done_o, srch_hit_o, srch_idx_o, rd_entry_o, inv_err_o);
  modport slave  (input  req_valid, req_op, inv_op, inv_asid, inv_va, csr, wr_entry,
                  output req_ready, tlb_write_req_o, done_o, srch_hit_o, srch_idx_o, rd_entry_o, inv_err_o);
endinterface

// File: rtl/tlb_maint_unit.sv
// LoongArch TLB maintenance: SRCH/RD/WR/FILL/INVTLB against a mirror of the mmu TLB.
// Build option TLB_FILL_LFSR_EN: FILL index from a free-running 8-bit LFSR instead of round-robin.
module tlb_maint_unit #(
  parameter int TLB_ENTRY_NUM = tlb_maint_pkg::TLB_ENTRY_NUM
) (
  input logic        clk,
  input logic        rst_n,
  tlb_maint_if.slave bus
);
  localparam int IDX_W = $clog2(TLB_ENTRY_NUM);
  typedef tlb_maint_pkg::tlb_entry_t     entry_t;
  typedef tlb_maint_pkg::tlb_write_req_t wreq_t;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_INV, S_DONE} state_t;

  state_t           state_q, state_d;
  entry_t           mirror [TLB_ENTRY_NUM];
  wreq_t            wreq_q, wreq_d;
  logic [2:0]       op_q;
  logic [4:0]       inv_op_q;
  logic [9:0]       asid_q;
  logic [18:0]      vppn_q;
  logic [IDX_W-1:0] idx_q, walk_q, walk_d, nidx, fill_idx, wr_idx, s_idx, srch_idx_q, srch_idx_d;
  logic             srch_hit_q, srch_hit_d, s_hit, inv_err_q, inv_err_d, inv_load;
  entry_t           rd_q, rd_d, wr_ent, cand;
  logic             accept, sig_unused;

  assign accept = bus.req_valid && bus.req_ready;
  assign sig_unused = ^{bus.csr.tlbelo0, bus.csr.tlbelo1, bus.csr.tlbidx.ps,
                        bus.csr.tlbidx.index[15:IDX_W], bus.inv_va[12:0]};

  function automatic logic va_hit(entry_t t, logic [18:0] vppn);
    if (t.key.ps == tlb_maint_pkg::PS_HUGE) return t.key.vppn[18:9] == vppn[18:9];
    return t.key.vppn == vppn;
  endfunction

  function automatic logic inv_hit(entry_t t, logic [4:0] op, logic [9:0] asid, logic [18:0] vppn);
    logic a;
    a = (t.key.asid == asid);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return t.key.g;
      5'd3:       return !t.key.g;
      5'd4:       return !t.key.g && a;
      5'd5:       return !t.key.g && a && va_hit(t, vppn);
      5'd6:       return (t.key.g || a) && va_hit(t, vppn);
      default:    return 1'b0;
    endcase
  endfunction

`ifdef TLB_FILL_LFSR_EN
  logic [7:0] lfsr_q;
  // Galois form of x^8+x^6+x^5+x^4+1, stepping every cycle regardless of traffic
  always_ff @(posedge clk)
    if (!rst_n) lfsr_q <= 8'd1;
    else        lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hb8 : 8'h00);
  assign fill_idx = lfsr_q[IDX_W-1:0];
`else
  logic [IDX_W-1:0] fill_q;
  always_ff @(posedge clk)
    if (!rst_n) fill_q <= '0;
    else if (accept && bus.req_op == tlb_maint_pkg::OP_FILL) fill_q <= fill_q + 1'b1;
  assign fill_idx = fill_q;
`endif

  always_comb begin
    wr_ent = bus.wr_entry;
    wr_ent.key.e = (bus.csr.estat.ecode == tlb_maint_pkg::ECODE_TLBR) || !bus.csr.tlbidx.ne;
    wr_idx = (bus.req_op == tlb_maint_pkg::OP_FILL) ? fill_idx : bus.csr.tlbidx.index[IDX_W-1:0];
  end

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    s_hit = 1'b0;
    s_idx = '0;
    for (int i = TLB_ENTRY_NUM-1; i >= 0; i--)
      if (mirror[i].key.e && (mirror[i].key.g || mirror[i].key.asid == asid_q) && va_hit(mirror[i], vppn_q)) begin
        s_hit = 1'b1;
        s_idx = i[IDX_W-1:0];
      end
  end

  always_comb begin
    state_d    = state_q;
    wreq_d     = '0;
    walk_d     = walk_q;
    srch_hit_d = srch_hit_q;
    srch_idx_d = srch_idx_q;
    rd_d       = rd_q;
    inv_err_d  = inv_err_q;
    // Write request is prepared one cycle ahead so it leaves straight from wreq_q
    nidx       = (state_q == S_INV) ? walk_q + 1'b1 : '0;
    cand       = mirror[nidx];
    cand.key.e = 1'b0;
    inv_load   = inv_hit(mirror[nidx], inv_op_q, asid_q, vppn_q);
    unique case (state_q)
      S_IDLE: if (accept) begin
        state_d    = S_EXEC;
        srch_hit_d = 1'b0;
        srch_idx_d = '0;
        rd_d       = '0;
        inv_err_d  = 1'b0;
        if (bus.req_op == tlb_maint_pkg::OP_WR || bus.req_op == tlb_maint_pkg::OP_FILL) begin
          wreq_d.we[wr_idx] = 1'b1;
          wreq_d.entry      = wr_ent;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        case (op_q)
          tlb_maint_pkg::OP_SRCH: begin srch_hit_d = s_hit; srch_idx_d = s_idx; end
          tlb_maint_pkg::OP_RD:   rd_d = mirror[idx_q];
          tlb_maint_pkg::OP_INV:
            if (inv_op_q > 5'd6) inv_err_d = 1'b1;
            else begin
              state_d = S_INV;
              walk_d  = '0;
              if (inv_load) begin wreq_d.we[nidx] = 1'b1; wreq_d.entry = cand; end
            end
          default: ;
        endcase
      end
      S_INV:
        if (walk_q == IDX_W'(TLB_ENTRY_NUM-1)) state_d = S_DONE;
        else begin
          walk_d = nidx;
          if (inv_load) begin wreq_d.we[nidx] = 1'b1; wreq_d.entry = cand; end
        end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  wreq_q <= '0;      walk_q <= '0;
      op_q <= '0;         inv_op_q <= '0;    asid_q <= '0;     vppn_q <= '0;  idx_q <= '0;
      srch_hit_q <= 1'b0; srch_idx_q <= '0;  rd_q <= '0;       inv_err_q <= 1'b0;
    end else begin
      state_q <= state_d;     wreq_q <= wreq_d;         walk_q <= walk_d;
      srch_hit_q <= srch_hit_d; srch_idx_q <= srch_idx_d; rd_q <= rd_d; inv_err_q <= inv_err_d;
      if (accept) begin
        op_q     <= bus.req_op;
        inv_op_q <= bus.inv_op;
        idx_q    <= bus.csr.tlbidx.index[IDX_W-1:0];
        asid_q   <= (bus.req_op == tlb_maint_pkg::OP_INV) ? bus.inv_asid : bus.csr.asid.asid;
        vppn_q   <= (bus.req_op == tlb_maint_pkg::OP_INV) ? bus.inv_va[31:13] : bus.csr.tlbehi.vppn;
      end
    end
  end

  // Only the valid bits are reset; the mmu clears its own array, payloads are don't-care
  always_ff @(posedge clk)
    for (int i = 0; i < TLB_ENTRY_NUM; i++)
      if (!rst_n)             mirror[i].key.e <= 1'b0;
      else if (wreq_q.we[i])  mirror[i] <= wreq_q.entry;

  assign bus.req_ready       = (state_q == S_IDLE);
  assign bus.done_o          = (state_q == S_DONE);
  assign bus.tlb_write_req_o = wreq_q;
  assign bus.srch_hit_o      = srch_hit_q;
  assign bus.srch_idx_o      = srch_idx_q;
  assign bus.rd_entry_o      = rd_q;
  assign bus.inv_err_o       = inv_err_q;
endmodule

// File: tb/tb_tlb_maint_unit.sv
// Randomized bench for tlb_maint_unit against an array-based TLB reference model.
module tb_tlb_maint_unit;
  import tlb_maint_pkg::*;
  localparam int N = TLB_ENTRY_NUM;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlb_maint_if bus();
  tlb_maint_unit #(.TLB_ENTRY_NUM(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int         n_vec = 0, n_err = 0;
  tlb_entry_t model [N];
  bit         known [N];
  int         fill_ptr = 0;
  logic [7:0] m_lfsr = 8'd1;

`ifdef TLB_FILL_LFSR_EN
  // Polynomial x^8+x^6+x^5+x^4+1, one step per clock while out of reset
  always @(posedge clk)
    if (!rst_n) m_lfsr <= 8'd1;
    else        m_lfsr <= (m_lfsr >> 1) ^ ((m_lfsr & 8'd1) != 0 ? 8'hb8 : 8'h00);
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit va_match(tlb_entry_t t, logic [18:0] vppn);
    if (t.key.ps == 6'd21) return (t.key.vppn >> 9) == (vppn >> 9);
    return t.key.vppn == vppn;
  endfunction

  function automatic int m_srch(logic [9:0] asid, logic [18:0] vppn);
    for (int i = 0; i < N; i++)
      if (model[i].key.e && (model[i].key.g || model[i].key.asid == asid) && va_match(model[i], vppn)) return i;
    return -1;
  endfunction

  function automatic bit inv_sel(tlb_entry_t t, int op, logic [9:0] asid, logic [18:0] vppn);
    bit a = (t.key.asid == asid);
    bit v = va_match(t, vppn);
    case (op)
      0, 1: return 1;
      2:    return t.key.g;
      3:    return !t.key.g;
      4:    return !t.key.g && a;
      5:    return !t.key.g && a && v;
      6:    return (t.key.g || a) && v;
      default: return 0;
    endcase
  endfunction

  function automatic tlb_entry_t rnd_entry();
    tlb_entry_t t;
    t = {$urandom, $urandom, $urandom};
    t.key.vppn = 19'h70000 + 19'($urandom_range(0, 3));
    t.key.ps   = ($urandom_range(0, 3) == 0) ? 6'd21 : 6'd12;
    t.key.asid = 10'($urandom_range(0, 3));
    return t;
  endfunction

  function automatic csr_t mk_csr(int idx, bit ne, logic [5:0] ecode, logic [18:0] vppn, logic [9:0] asid);
    csr_t c;
    c = '0;
    c.tlbelo0 = $urandom;
    c.tlbelo1 = $urandom;
    c.tlbidx.index = 16'(idx);
    c.tlbidx.ne = ne;
    c.estat.ecode = ecode;
    c.tlbehi.vppn = vppn;
    c.asid.asid = asid;
    return c;
  endfunction

  task automatic run_op(input logic [2:0] op, input int iop, input logic [9:0] iasid, input logic [31:0] iva,
                        input csr_t c, input tlb_entry_t went);
    logic [N-1:0] exp_we  [128];
    tlb_entry_t   exp_ent [128];
    int           exp_lat, exp_idx, k, widx, ridx;
    bit           exp_err;
    tlb_entry_t   nw;
    for (int i = 0; i < 128; i++) begin exp_we[i] = '0; exp_ent[i] = '0; end
    exp_lat = 2; exp_err = 0; exp_idx = -1; ridx = int'(c.tlbidx.index) % N; widx = ridx;

    @(negedge clk);
    chk("ready_pre", 128'(bus.req_ready), 128'(1));
    bus.req_valid = 1'b1; bus.req_op = op; bus.inv_op = 5'(iop);
    bus.inv_asid = iasid; bus.inv_va = iva; bus.csr = c; bus.wr_entry = went;

    if (op == OP_SRCH) exp_idx = m_srch(c.asid.asid, c.tlbehi.vppn);
    if (op == OP_WR || op == OP_FILL) begin
`ifdef TLB_FILL_LFSR_EN
      if (op == OP_FILL) widx = int'(m_lfsr) % N;
`else
      if (op == OP_FILL) begin widx = fill_ptr; fill_ptr = (fill_ptr + 1) % N; end
`endif
      nw = went;
      nw.key.e = (c.estat.ecode == 6'h3f) ? 1'b1 : !c.tlbidx.ne;
      exp_we[1][widx] = 1'b1; exp_ent[1] = nw;
    end
    if (op == OP_INV) begin
      if (iop > 6) exp_err = 1;
      else begin
        exp_lat = N + 2;
        for (int i = 0; i < N; i++)
          if (inv_sel(model[i], iop, iasid, iva[31:13])) begin
            exp_we[i+2][i] = 1'b1; exp_ent[i+2] = model[i]; exp_ent[i+2].key.e = 1'b0;
          end
      end
    end

    @(negedge clk);
    bus.req_valid = 1'b0;
    k = 1;
    forever begin
      chk($sformatf("we@%0d op%0d", k, op), 128'(bus.tlb_write_req_o.we), 128'(exp_we[k]));
      if (exp_we[k] != '0) begin
        int wi = $clog2(exp_we[k]);
        if (op == OP_INV && !known[wi])
          chk("wr_e", 128'(bus.tlb_write_req_o.entry.key.e), 128'(0));
        else
          chk($sformatf("wr_ent@%0d", k), 128'(bus.tlb_write_req_o.entry), 128'(exp_ent[k]));
      end
      if (bus.done_o || k >= 100) break;
      @(negedge clk);
      k++;
    end
    chk($sformatf("latency op%0d", op), 128'(k), 128'(exp_lat));
    chk("ready_in_done", 128'(bus.req_ready), 128'(0));
    chk("inv_err", 128'(bus.inv_err_o), 128'(exp_err));
    if (op == OP_SRCH) begin
      chk("srch_hit", 128'(bus.srch_hit_o), 128'(exp_idx >= 0));
      if (exp_idx >= 0) chk("srch_idx", 128'(bus.srch_idx_o), 128'(exp_idx));
    end
    if (op == OP_RD) begin
      if (known[ridx]) chk("rd_entry", 128'(bus.rd_entry_o), 128'(model[ridx]));
      else             chk("rd_e", 128'(bus.rd_entry_o.key.e), 128'(model[ridx].key.e));
    end

    if (op == OP_WR || op == OP_FILL) begin model[widx] = nw; known[widx] = 1; end
    if (op == OP_INV && iop <= 6)
      for (int i = 0; i < N; i++) if (inv_sel(model[i], iop, iasid, iva[31:13])) model[i].key.e = 1'b0;

    @(negedge clk);
    chk("ready_post", 128'(bus.req_ready), 128'(1));
  endtask

  initial begin
    tlb_entry_t t;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.inv_op = '0; bus.inv_asid = '0; bus.inv_va = '0;
    bus.csr = '0; bus.wr_entry = '0;
    for (int i = 0; i < N; i++) begin model[i] = '0; known[i] = 0; end

    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(bus.req_ready), 128'(1));
    chk("rst_done", 128'(bus.done_o), 128'(0));
    chk("rst_we", 128'(bus.tlb_write_req_o), 128'(0));
    chk("rst_res", 128'({bus.srch_hit_o, bus.srch_idx_o, bus.inv_err_o, bus.rd_entry_o}), 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) run_op(OP_WR, 0, 0, 0, mk_csr(i, 0, 6'h0, 0, 0), rnd_entry());
    for (int i = 0; i < N + 1; i++)
      run_op(OP_FILL, 0, 0, 0, mk_csr($urandom, $urandom_range(0, 1), 6'h3f, 0, 0), rnd_entry());

    // Directed: WR/RD at 5, SRCH priority, INV op5, INV error, INV all
    t = rnd_entry(); t.key.vppn = 19'h12345; t.key.ps = 6'd12; t.key.g = 0; t.key.asid = 10'd1;
    run_op(OP_WR, 0, 0, 0, mk_csr(5, 0, 6'h0, 0, 0), t);
    run_op(OP_RD, 0, 0, 0, mk_csr(16'h8005, 0, 6'h0, 0, 0), '0);
    t.key.asid = 10'd7;
    run_op(OP_WR, 0, 0, 0, mk_csr(3, 0, 6'h0, 0, 0), t);
    run_op(OP_WR, 0, 0, 0, mk_csr(9, 0, 6'h0, 0, 0), t);
    run_op(OP_SRCH, 0, 0, 0, mk_csr(0, 0, 6'h0, 19'h12345, 10'd7), '0);
    chk("dir_srch_idx3", 128'(bus.srch_idx_o), 128'(3));
    run_op(OP_SRCH, 0, 0, 0, mk_csr(0, 0, 6'h0, 19'h12345, 10'd8), '0);
    t.key.g = 1;
    run_op(OP_WR, 0, 0, 0, mk_csr(3, 0, 6'h0, 0, 0), t);
    run_op(OP_INV, 5, 10'd7, 32'h2468a000, mk_csr(0, 0, 6'h0, 0, 0), '0);
    chk("dir_e9_cleared", 128'(model[9].key.e), 128'(0));
    run_op(OP_SRCH, 0, 0, 0, mk_csr(0, 0, 6'h0, 19'h12345, 10'd7), '0);
    run_op(OP_INV, 9, 0, 0, mk_csr(0, 0, 6'h0, 0, 0), '0);
    run_op(OP_INV, 0, 0, 0, mk_csr(0, 0, 6'h0, 0, 0), '0);

    for (int n = 0; n < 160; n++) begin
      int r = $urandom_range(0, 99);
      logic [2:0] op = (r < 25) ? OP_SRCH : (r < 45) ? OP_RD : (r < 70) ? OP_WR : (r < 85) ? OP_FILL : OP_INV;
      logic [18:0] vp = 19'h70000 + 19'($urandom_range(0, 3));
      run_op(op, $urandom_range(0, 7), 10'($urandom_range(0, 3)), {vp, 13'($urandom)},
             mk_csr($urandom, $urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? 6'h3f : 6'($urandom_range(0, 62)),
                    vp, 10'($urandom_range(0, 3))),
             rnd_entry());
    end

    // Reset in the middle of an INVTLB-all walk, at entry 20
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_INV; bus.inv_op = 5'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (21) @(negedge clk);
    chk("walk20", 128'(bus.tlb_write_req_o.we), 128'(64'd1 << 20));
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ready", 128'(bus.req_ready), 128'(1));
    chk("abort_we", 128'(bus.tlb_write_req_o.we), 128'(0));
    chk("abort_done", 128'(bus.done_o), 128'(0));
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) model[i].key.e = 1'b0;
    fill_ptr = 0;
    for (int n = 0; n < 4; n++) run_op(OP_RD, 0, 0, 0, mk_csr($urandom, 0, 6'h0, 0, 0), '0);
    run_op(OP_FILL, 0, 0, 0, mk_csr(0, 0, 6'h0, 0, 0), rnd_entry());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
